output_buffer_drain: RTL
========================

// Module: output_buffer_drain
// PURPOSE
//  Receiving end of the accumulator's output-buffer write interface: DEPTH x DATA_W result store.
//  Entries are written by address with a per-entry valid bit.
//  On drain_start, a scan FSM streams every valid entry to the host in ascending address order.
//  Uses a valid/ready handshake and clears each entry as it is accepted.
// PARAMETERS
//  DEPTH   16  number of entries (power of two)
//  ADDR_W  4   address width, log2(DEPTH)
//  DATA_W  32  entry width (bfp32 result word)
// PORTS
//  clk            in   1         single clock, all state on posedge
//  rst            in   1         reset; asynchronous, active-low
//  wr_en          in   1         write strobe from accumulator (output_buffer_enable)
//  wr_addr        in   ADDR_W    write address (output_buffer_addr)
//  wr_data        in   DATA_W    write data (output_data)
//  drain_start    in   1         start a drain pass; honoured only in IDLE
//  flush          in   1         clear all valid bits and abort any drain
//  out_valid      out  1         out_data/out_addr hold a beat
//  out_ready      in   1         host accepts beat when out_valid & out_ready
//  out_data       out  DATA_W    drained entry data
//  out_addr       out  ADDR_W    address of drained entry
//  busy           out  1         FSM not in IDLE
//  drain_done     out  1         one-cycle pulse at end of drain pass
//  occupancy      out  ADDR_W+1  number of valid entries (0..DEPTH)
//  full           out  1         occupancy == DEPTH
//  overwrite_flag out  1         sticky: write hit an already-valid entry
// BEHAVIOUR
//  Reset (rst=0, async): all valid bits 0, state IDLE, ptr 0. Outputs at reset:
//   out_valid=0, out_data=0, out_addr=0, busy=0, drain_done=0, occupancy=0, full=0, overwrite_flag=0.
//   Storage data is not reset. Reset mid-drain aborts the drain with no drain_done pulse.
//  Write: at the posedge with wr_en=1: mem[wr_addr]<=wr_data, valid[wr_addr]<=1.
//   Write is accepted in every state, including during a drain.
//   If valid[wr_addr] was already 1 (and is not being cleared this cycle), set overwrite_flag.
//   overwrite_flag is cleared only by reset or by an accepted drain_start.
//  occupancy/full are registered and track valid bits with the same timing; no underflow or overflow.
//  FSM states and transitions:
//   IDLE: on drain_start, go to SCAN with ptr<=0; busy=1 from the next cycle.
//   SCAN: one entry per cycle.
//    If valid[ptr]: out_data<=mem[ptr], out_addr<=ptr, out_valid<=1, go to PRESENT.
//    Else if ptr==DEPTH-1: go to DONE.
//    Else: ptr<=ptr+1.
//   PRESENT: out_valid=1; out_data/out_addr are held stable until the handshake.
//    On handshake: out_valid<=0 and valid[ptr]<=0.
//    Then go to DONE if ptr==DEPTH-1, else ptr<=ptr+1 and go to SCAN.
//   DONE: drain_done=1 for exactly one cycle, then IDLE.
//  Latency: drain_start at edge N gives SCAN at N+1. With entry 0 valid, out_valid is high after edge N+2.
//  Write to ptr in the same cycle as its handshake: the write wins.
//   valid stays 1 with the new data; the old snapshot is the beat delivered.
//   The entry is kept for the next pass and is not counted as an overwrite.
//  A write to an address > ptr during a drain is drained in this pass; a write to an address <= ptr is not.
//  flush: highest priority after reset.
//   Clears all valid bits, occupancy<=0, state<=IDLE, out_valid<=0, no drain_done.
//   A wr_en in the same cycle is dropped.
//  drain_start while busy is ignored. A drain with zero valid entries reaches DONE after DEPTH SCAN cycles.
// TESTING
//  Reset: rst=0 mid-drain with out_valid=1 -> all outputs 0 immediately (async), occupancy=0.
//  Write 0xDEADBEEF@3 and 0x3F800000@7, drain_start, out_ready=1 ->
//   beats (3,0xDEADBEEF) then (7,0x3F800000), then one drain_done pulse; occupancy 2->1->0.
//  Backpressure: entry@0 valid, out_ready=0 for 5 cycles ->
//   out_valid held, out_data/out_addr stable; exactly 1 beat accepted when ready rises.
//  Write 16 distinct entries -> full=1, occupancy=16.
//   Rewrite @5 -> overwrite_flag=1, occupancy stays 16; drain delivers 16 beats in order 0..15.
//  Collisions during drain, @2 presented:
//   write @2 on its handshake -> after pass occupancy=1 and entry 2 holds the new data;
//   write @9 mid-pass -> drained in this pass.
//  flush during PRESENT -> out_valid=0 next cycle, busy=0, occupancy=0, no drain_done.
//   Empty drain -> drain_done exactly DEPTH+2 cycles after drain_start.

Source files
------------

// File: rtl/output_buffer_drain.sv
// Output-buffer result store: entries are written by address with a per-entry valid bit.
// A scan FSM streams the valid entries to the host over valid/ready and clears each one on acceptance.
module output_buffer_drain #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_start,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              drain_done,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              overwrite_flag
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PRESENT,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W:0]     occ_q, occ_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic handshake;
  logic wr_hits_ptr;
  logic ptr_last;
  logic mem_we;

  assign handshake   = (state_q == ST_PRESENT) && out_ready;
  assign wr_hits_ptr = wr_en && (wr_addr == ptr_q);
  assign ptr_last    = (ptr_q == PTR_LAST);
  assign mem_we      = wr_en && !flush;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    valid_d     = valid_q;
    occ_d       = occ_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_SCAN: begin
        if (valid_q[ptr_q]) begin
          out_data_d  = mem_q[ptr_q];
          out_addr_d  = ptr_q;
          out_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end else if (ptr_last) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
      ST_PRESENT: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          // A write landing on the accepted entry keeps it valid for the next pass.
          if (!wr_hits_ptr) begin
            valid_d[ptr_q] = 1'b0;
            occ_d          = occ_d - OCC_ONE;
          end
          if (ptr_last) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr_q + PTR_ONE;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      if (valid_q[wr_addr] && !(handshake && wr_hits_ptr)) begin
        ovf_d = 1'b1;
      end
      if (!valid_q[wr_addr]) begin
        occ_d = occ_d + OCC_ONE;
      end
      valid_d[wr_addr] = 1'b1;
    end

    if (flush) begin
      state_d     = ST_IDLE;
      valid_d     = '0;
      occ_d       = '0;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    full_d = (occ_d == OCC_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      valid_q     <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_addr       = out_addr_q;
  assign busy           = (state_q != ST_IDLE);
  assign drain_done     = done_q;
  assign occupancy      = occ_q;
  assign full           = full_q;
  assign overwrite_flag = ovf_q;

endmodule
